vga_scanout: RTL



---
 rtl/vga_scanout.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// VGA scanout: snapshots the framebuffer at vblank, scales pixels and emits 3-3-2 colour with syncs.
// Latency 1 clk from counter position to outputs; no backpressure, free-running on the pixel tick.
module vga_scanout #(
  parameter int PX_WIDTH  = 80,
  parameter int PX_HEIGHT = 60,
  parameter int SCALE     = 8,
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PX_WIDTH*PX_HEIGHT*3:0]     pixel,
  output logic [2:0]                        vgaRed,
  output logic [2:0]                        vgaGreen,
  output logic [1:0]                        vgaBlue,
  output logic                              Hsync,
  output logic                              Vsync,
  output logic                              frame_start
);

  localparam int FB_BITS  = PX_WIDTH * PX_HEIGHT * 3;
  localparam int SHIFT    = $clog2(SCALE);
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W      = $clog2(H_TOTAL);
  localparam int V_W      = $clog2(V_TOTAL);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SEL_W    = (FB_BITS > 1) ? $clog2(FB_BITS) : 1;
  localparam int HS_FIRST = H_VISIBLE + H_FRONT;
  localparam int HS_LAST  = H_VISIBLE + H_FRONT + H_SYNC - 1;
  localparam int VS_FIRST = V_VISIBLE + V_FRONT;
  localparam int VS_LAST  = V_VISIBLE + V_FRONT + V_SYNC - 1;

  logic [DIV_W-1:0]   div;
  logic               tick;
  logic [H_W-1:0]     h;
  logic [V_W-1:0]     v;
  logic [FB_BITS-1:0] shadow;

  logic               h_last;
  logic               v_last;
  logic               snap;
  logic               visible;
  logic               in_fb;
  logic [31:0]        lx;
  logic [31:0]        ly;
  logic [31:0]        pix_idx;
  logic [31:0]        bit_base;
  logic [SEL_W-1:0]   bit_sel;
  logic [2:0]         colour;
  logic [2:0]         red_nxt;
  logic [2:0]         green_nxt;
  logic [1:0]         blue_nxt;
  logic               hsync_nxt;
  logic               vsync_nxt;
  logic               unused_pixel_top;

  assign unused_pixel_top = pixel[FB_BITS];

  // Pixel tick divider
  assign tick = (div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign h_last = (h == H_W'(H_TOTAL - 1));
  assign v_last = (v == V_W'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Snapshot at the top-left of vertical blanking keeps redraws from tearing
  assign snap = tick && (h == '0) && (v == V_W'(V_VISIBLE));

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= snap;
      if (snap) begin
        shadow <= pixel[FB_BITS-1:0];
      end
    end
  end

  // Framebuffer lookup with SCALE x SCALE replication
  always_comb begin
    visible  = (h < H_W'(H_VISIBLE)) && (v < V_W'(V_VISIBLE));
    in_fb    = (32'(h) < 32'(PX_WIDTH * SCALE)) && (32'(v) < 32'(PX_HEIGHT * SCALE));
    lx       = 32'(h) >> SHIFT;
    ly       = 32'(v) >> SHIFT;
    pix_idx  = in_fb ? (ly * 32'(PX_WIDTH) + lx) : 32'd0;
    bit_base = pix_idx * 32'd3;
    bit_sel  = SEL_W'(bit_base);
    colour   = (in_fb && visible) ? shadow[bit_sel +: 3] : 3'b000;
  end

  always_comb begin
    red_nxt   = {3{colour[2]}};
    green_nxt = {3{colour[1]}};
    blue_nxt  = {2{colour[0]}};
    hsync_nxt = !((h >= H_W'(HS_FIRST)) && (h <= H_W'(HS_LAST)));
    vsync_nxt = !((v >= V_W'(VS_FIRST)) && (v <= V_W'(VS_LAST)));
  end

  // Outputs register the pre-increment position so colour and sync stay aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      vgaRed   <= '0;
      vgaGreen <= '0;
      vgaBlue  <= '0;
      Hsync    <= 1'b1;
      Vsync    <= 1'b1;
    end else if (tick) begin
      vgaRed   <= red_nxt;
      vgaGreen <= green_nxt;
      vgaBlue  <= blue_nxt;
      Hsync    <= hsync_nxt;
      Vsync    <= vsync_nxt;
    end
  end

endmodule
